// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps the PC, issues fixed-latency instruction
// memory reads and buffers returned instructions in a 2-entry FIFO for decode.
module fetch_stage #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = 32'h0000_0000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      stall_i,
    input  logic                      redirect_i,
    input  logic [ADDRESS_WIDTH-1:0]  redirect_pc_i,
    output logic                      imem_req_o,
    output logic [ADDRESS_WIDTH-1:0]  imem_addr_o,
    input  logic [DATA_WIDTH-1:0]     imem_rdata_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [ADDRESS_WIDTH-1:0]  pc_o,
    output logic [ADDRESS_WIDTH-1:0]  pc_plus4_o,
    output logic [DATA_WIDTH-1:0]     instr_o
);

    localparam logic [DATA_WIDTH-1:0]    NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP   = ADDRESS_WIDTH'(4);

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]               count_q, count_d;
    logic                     inflight_q, inflight_d;
    logic [ADDRESS_WIDTH-1:0] inflightPc_q, inflightPc_d;
    logic                     rdPtr_q, rdPtr_d;
    logic                     wrPtr_q, wrPtr_d;
    logic [ADDRESS_WIDTH-1:0] fifoPc_q    [2];
    logic [DATA_WIDTH-1:0]    fifoInstr_q [2];

    logic       pop;
    logic       push;
    logic       req;
    logic [2:0] pending;
    logic [1:0] unusedLowBits;

    assign unusedLowBits = redirect_pc_i[1:0];

    // Handshake decode: pop on accept, push whenever a response returns unflushed,
    // request only when the FIFO is guaranteed to have room for the response.
    always_comb begin
        valid_o = (count_q != 2'd0);
        pop     = valid_o && ready_i;
        push    = inflight_q && !redirect_i;
        pending = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        req     = rst_ni && !redirect_i && !stall_i && (pending <= 3'd1);
    end

    assign imem_req_o  = req;
    assign imem_addr_o = pc_q;

    // Next-state for PC, in-flight tracking and FIFO bookkeeping; redirect flushes everything.
    always_comb begin
        pc_d         = pc_q;
        inflight_d   = req;
        inflightPc_d = inflightPc_q;
        count_d      = count_q;
        rdPtr_d      = rdPtr_q;
        wrPtr_d      = wrPtr_q;
        if (redirect_i) begin
            pc_d    = {redirect_pc_i[ADDRESS_WIDTH-1:2], 2'b00};
            count_d = 2'd0;
            rdPtr_d = 1'b0;
            wrPtr_d = 1'b0;
        end else begin
            if (req) begin
                pc_d         = pc_q + PC_STEP;
                inflightPc_d = pc_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            rdPtr_d = rdPtr_q ^ pop;
            wrPtr_d = wrPtr_q ^ push;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q         <= RESET_PC;
            count_q      <= 2'd0;
            inflight_q   <= 1'b0;
            inflightPc_q <= '0;
            rdPtr_q      <= 1'b0;
            wrPtr_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
        end
    end

    // FIFO storage: write the returning response at the tail.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifoPc_q[0]    <= '0;
            fifoPc_q[1]    <= '0;
            fifoInstr_q[0] <= '0;
            fifoInstr_q[1] <= '0;
        end else if (push) begin
            fifoPc_q[wrPtr_q]    <= inflightPc_q;
            fifoInstr_q[wrPtr_q] <= imem_rdata_i;
        end
    end

    // Head entry to decode, or a NOP at PC 0 when nothing is buffered.
    always_comb begin
        pc_o       = '0;
        pc_plus4_o = PC_STEP;
        instr_o    = NOP_INSTR;
        if (valid_o) begin
            pc_o       = fifoPc_q[rdPtr_q];
            pc_plus4_o = fifoPc_q[rdPtr_q] + PC_STEP;
            instr_o    = fifoInstr_q[rdPtr_q];
        end
    end

    // The request throttle must make a push into a full FIFO unreachable.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && (count_q == 2'd2)));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a fixed-latency memory model feeds the
// DUT and a scoreboard of expected {pc, instr} entries checks every accepted fetch.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] instr_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      expQ[$];
    logic [31:0] genPc;
    int          errors = 0;
    int          checks = 0;

    fetch_stage #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .stall_i(stall_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imem_rdata_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .pc_o(pc_o),
        .pc_plus4_o(pc_plus4_o),
        .instr_o(instr_o)
    );

    always #5 clk_i = ~clk_i;

    // Distinct, address-dependent instruction word for every fetch address
    function automatic logic [31:0] instrFor(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: data returned one cycle after the request cycle
    always @(posedge clk_i) begin
        if (imem_req_o) imem_rdata_i <= instrFor(imem_addr_o);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic refillModel();
        while (expQ.size() < 4) begin
            expQ.push_back('{pc: genPc, instr: instrFor(genPc)});
            genPc = genPc + 32'd4;
        end
    endtask

    task automatic restartModel(input logic [31:0] start);
        expQ.delete();
        genPc = start;
        refillModel();
    endtask

    // Drive one cycle of inputs, score any accepted entry, then let the edge happen
    task automatic applyStimulus(input logic stall, input logic redirect,
                                 input logic [31:0] rpc, input logic ready);
        entry_t e;
        @(negedge clk_i);
        stall_i       = stall;
        redirect_i    = redirect;
        redirect_pc_i = rpc;
        ready_i       = ready;
        #1;
        if (valid_o && ready_i) begin
            e = expQ.pop_front();
            checkOutput("headPc", pc_o, e.pc);
            checkOutput("headPc4", pc_plus4_o, e.pc + 32'd4);
            checkOutput("headInstr", instr_o, e.instr);
            refillModel();
        end else if (!valid_o) begin
            checkOutput("idlePc", pc_o, 32'h0);
            checkOutput("idleInstr", instr_o, 32'h0000_0013);
        end
        if (redirect) restartModel({rpc[31:2], 2'b00});
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstValid", {31'b0, valid_o}, 32'd0);
        checkOutput("rstReq", {31'b0, imem_req_o}, 32'd0);
        checkOutput("rstAddr", imem_addr_o, 32'h0);
        checkOutput("rstPc", pc_o, 32'h0);
        checkOutput("rstPc4", pc_plus4_o, 32'h4);
        checkOutput("rstInstr", instr_o, 32'h0000_0013);
    endtask

    initial begin
        restartModel(32'h0);

        // Reset state and startup stream
        repeat (2) @(negedge clk_i);
        #1 checkResetOutputs();
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("start1Req", {31'b0, imem_req_o}, 32'd1);
        checkOutput("start1Addr", imem_addr_o, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("start2Addr", imem_addr_o, 32'h4);
        checkOutput("start2Valid", {31'b0, valid_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("start3Valid", {31'b0, valid_o}, 32'd1);
        checkOutput("start3Addr", imem_addr_o, 32'h8);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Decode back-pressure fills the FIFO and throttles requests
        repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("bpValid", {31'b0, valid_o}, 32'd1);
        checkOutput("bpReq", {31'b0, imem_req_o}, 32'd0);
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect with a full FIFO: flush, refetch from aligned target
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        checkOutput("redirReq", {31'b0, imem_req_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("redir1Valid", {31'b0, valid_o}, 32'd0);
        checkOutput("redir1Req", {31'b0, imem_req_o}, 32'd1);
        checkOutput("redir1Addr", imem_addr_o, 32'h100);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("redir2Valid", {31'b0, valid_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("redir3Valid", {31'b0, valid_o}, 32'd1);
        checkOutput("redir3Pc", pc_o, 32'h100);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Stall: in-flight response still lands, PC held, pops continue
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput("stallReq", {31'b0, imem_req_o}, 32'd0);
            checkOutput("stallAddr", imem_addr_o, 32'h114);
        end
        applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        checkOutput("stallRedirReq", {31'b0, imem_req_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("postStallReq", {31'b0, imem_req_o}, 32'd1);
        checkOutput("postStallAddr", imem_addr_o, 32'h200);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect with a concurrent pop, then PC wrap-around
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrapAddr1", imem_addr_o, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrapAddr2", imem_addr_o, 32'h0000_0000);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrapHeadPc", pc_o, 32'hFFFF_FFFC);
        checkOutput("wrapHeadPc4", pc_plus4_o, 32'h0000_0000);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Asynchronous reset mid-stream with a full FIFO
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("preRstValid", {31'b0, valid_o}, 32'd1);
        @(negedge clk_i);
        ready_i = 1'b1;
        #2 rst_ni = 1'b0;
        #1 checkResetOutputs();
        restartModel(32'h0);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rerstReq", {31'b0, imem_req_o}, 32'd1);
        checkOutput("rerstAddr", imem_addr_o, 32'h0);
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
